// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer
// ----------------------------------------------------------------------------
// Fetch-stage program counter for the MIPS core. Holds the current fetch PC
// and sequences it under stall and fetch backpressure. Handles branch/jump
// redirects, call/return through a small circular return-address stack, and
// exception vectoring with EPC capture.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   stall            hold PC (pipeline hazard)
//   fetch_ready      instruction memory accepts the current pc_out
//   redirect_valid   take redirect_target this cycle
//   redirect_target  branch/jump destination
//   redirect_call    redirect is a call: push return address
//   ret_valid        return: pop the RAS (held off until the PC can advance)
//   exc_valid        exception request
//   pc_out           current fetch address
//   pc_valid         pc_out is a real fetch request
//   epc_out          PC captured at the last exception
//   misaligned       one-cycle pulse: redirect target had nonzero low bits
//   ret_miss         one-cycle pulse: return requested with the RAS empty
//   ras_empty        RAS holds no entries
//   ras_full         RAS holds RAS_DEPTH entries
// ============================================================================
module pc_sequencer #(
    parameter int              ADDR_W    = 32,
    parameter int              STEP      = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0000_0080,
    parameter int              RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              fetch_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              redirect_call,
    input  logic              ret_valid,
    input  logic              exc_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_valid,
    output logic [ADDR_W-1:0] epc_out,
    output logic              misaligned,
    output logic              ret_miss,
    output logic              ras_empty,
    output logic              ras_full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TRAP = 2'd2;

    localparam logic [ADDR_W-1:0] STEP_V   = ADDR_W'(STEP);
    // Low bits that must be zero in an aligned fetch address.
    localparam logic [ADDR_W-1:0] ALIGN_M  = STEP_V - {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W+1)'(RAS_DEPTH);

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              pc_valid_reg, pc_valid_next;
    logic [ADDR_W-1:0] epc_reg, epc_next;
    logic              misaligned_reg, misaligned_next;
    logic              ret_miss_reg, ret_miss_next;

    // RAS: wp_reg points at the next free slot; the top of stack is wp_reg-1.
    // Pushing past capacity simply keeps wrapping, which overwrites the oldest
    // entry while count saturates at RAS_DEPTH.
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  wp_reg, wp_next;
    logic [PTR_W:0]    count_reg, count_next;
    logic              ras_empty_reg, ras_full_reg;
    logic              push, pop;
    logic [PTR_W-1:0]  top_idx;

    logic              adv;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] ret_addr;

    assign adv      = fetch_ready & ~stall;
    assign pc_inc   = pc_reg + STEP_V;
    assign top_idx  = wp_reg - PTR_W'(1);
    // The pop must redirect on the same edge, so the stack top is read
    // combinationally; the array is tiny and maps to distributed storage.
    assign ret_addr = ras_mem[top_idx];

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pc_valid_next   = pc_valid_reg;
        epc_next        = epc_reg;
        misaligned_next = 1'b0;
        ret_miss_next   = 1'b0;
        push            = 1'b0;
        pop             = 1'b0;

        case (state_reg)
            ST_BOOT, ST_TRAP: begin
                // Single bubble; the PC is already where fetch should start.
                state_next    = ST_RUN;
                pc_valid_next = 1'b1;
            end
            ST_RUN: begin
                if (exc_valid) begin
                    epc_next      = pc_reg;
                    pc_next       = EXC_VEC;
                    state_next    = ST_TRAP;
                    pc_valid_next = 1'b0;
                end else if (redirect_valid) begin
                    pc_next         = redirect_target & ~ALIGN_M;
                    misaligned_next = |(redirect_target & ALIGN_M);
                    push            = redirect_call;
                end else if (ret_valid && adv) begin
                    if (count_reg != '0) begin
                        pop     = 1'b1;
                        pc_next = ret_addr;
                    end else begin
                        pc_next       = pc_inc;
                        ret_miss_next = 1'b1;
                    end
                end else if (adv) begin
                    pc_next = pc_inc;
                end
            end
            default: begin
                state_next    = ST_BOOT;
                pc_valid_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        wp_next    = wp_reg;
        count_next = count_reg;
        if (push) begin
            wp_next = wp_reg + PTR_W'(1);
            if (count_reg != DEPTH_C) begin
                count_next = count_reg + (PTR_W+1)'(1);
            end
        end else if (pop) begin
            wp_next    = top_idx;
            count_next = count_reg - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_BOOT;
            pc_reg         <= RESET_VEC;
            pc_valid_reg   <= 1'b0;
            epc_reg        <= '0;
            misaligned_reg <= 1'b0;
            ret_miss_reg   <= 1'b0;
            wp_reg         <= '0;
            count_reg      <= '0;
            ras_empty_reg  <= 1'b1;
            ras_full_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pc_valid_reg   <= pc_valid_next;
            epc_reg        <= epc_next;
            misaligned_reg <= misaligned_next;
            ret_miss_reg   <= ret_miss_next;
            wp_reg         <= wp_next;
            count_reg      <= count_next;
            // Flags are derived from the next count so they track it exactly.
            ras_empty_reg  <= (count_next == '0);
            ras_full_reg   <= (count_next == DEPTH_C);
        end
    end

    // Stack storage carries no reset; count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[wp_reg] <= pc_inc;
        end
    end

    assign pc_out     = pc_reg;
    assign pc_valid   = pc_valid_reg;
    assign epc_out    = epc_reg;
    assign misaligned = misaligned_reg;
    assign ret_miss   = ret_miss_reg;
    assign ras_empty  = ras_empty_reg;
    assign ras_full   = ras_full_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer
// ----------------------------------------------------------------------------
// Directed testbench for pc_sequencer with default parameters. Inputs change
// 1 ns after the rising edge; outputs are sampled at that same point, so each
// sample reflects the edge just taken.
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        redirect_call;
    logic        ret_valid;
    logic        exc_valid;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic [31:0] epc_out;
    logic        misaligned;
    logic        ret_miss;
    logic        ras_empty;
    logic        ras_full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .fetch_ready     (fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .redirect_call   (redirect_call),
        .ret_valid       (ret_valid),
        .exc_valid       (exc_valid),
        .pc_out          (pc_out),
        .pc_valid        (pc_valid),
        .epc_out         (epc_out),
        .misaligned      (misaligned),
        .ret_miss        (ret_miss),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Jump to an address with no call and no other request.
    task automatic go_to(input logic [31:0] addr);
        redirect_valid  = 1'b1;
        redirect_target = addr;
        redirect_call   = 1'b0;
        step();
        redirect_valid  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        reset = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
        redirect_valid = 1'b0; redirect_target = '0; redirect_call = 1'b0;
        ret_valid = 1'b0; exc_valid = 1'b0;
        repeat (3) step();
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h0); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pc_valid); end
        checks++; if (epc_out !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h expected 0", epc_out); end
        checks++; if ({ras_empty, ras_full, misaligned, ret_miss} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags: got %b expected 1000", {ras_empty, ras_full, misaligned, ret_miss}); end
        reset = 1'b1;
        step();
        checks++; if (pc_valid !== 1'b1 || pc_out !== 32'h0) begin
            errors++; $display("FAIL boot_first: got valid=%b pc=%h expected valid=1 pc=0", pc_valid, pc_out); end
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_pc = 32'(4 * i);
            checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL boot_seq%0d: got %h expected %h", i, pc_out, exp_pc); end
        end
        // Asynchronous reset mid-cycle: must act before the next edge.
        reset = 1'b0;
        #2;
        checks++; if (pc_out !== 32'h0 || pc_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: got pc=%h valid=%b expected pc=0 valid=0", pc_out, pc_valid); end
        step();
        reset = 1'b1;
        step();
        checks++; if (pc_valid !== 1'b1 || pc_out !== 32'h0) begin
            errors++; $display("FAIL reboot: got valid=%b pc=%h expected valid=1 pc=0", pc_valid, pc_out); end
        $display("test_reset done");
    endtask

    task automatic test_stall();
        go_to(32'h40);
        stall = 1'b1;
        checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL stall_start: got %h expected 40", pc_out); end
        step();
        checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL stall_1: got %h expected 40", pc_out); end
        step();
        checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL stall_2: got %h expected 40", pc_out); end
        stall = 1'b0; fetch_ready = 1'b0;
        step();
        checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL backpressure: got %h expected 40", pc_out); end
        fetch_ready = 1'b1;
        step();
        checks++; if (pc_out !== 32'h44) begin errors++; $display("FAIL stall_release: got %h expected 44", pc_out); end
        $display("test_stall done");
    endtask

    task automatic test_redirect();
        go_to(32'h100);
        stall = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h203;
        step();
        redirect_valid = 1'b0;
        checks++; if (pc_out !== 32'h200 || misaligned !== 1'b1) begin
            errors++; $display("FAIL redirect_misaligned: got pc=%h mis=%b expected pc=200 mis=1", pc_out, misaligned); end
        step();
        checks++; if (pc_out !== 32'h200 || misaligned !== 1'b0) begin
            errors++; $display("FAIL misaligned_pulse: got pc=%h mis=%b expected pc=200 mis=0", pc_out, misaligned); end
        go_to(32'h100);
        // Exception outranks the simultaneous misaligned redirect.
        redirect_valid = 1'b1; redirect_target = 32'h203; exc_valid = 1'b1;
        step();
        redirect_valid = 1'b0; exc_valid = 1'b0; stall = 1'b0;
        checks++; if (pc_out !== 32'h80 || epc_out !== 32'h100 || pc_valid !== 1'b0 || misaligned !== 1'b0) begin
            errors++; $display("FAIL exception: got pc=%h epc=%h valid=%b mis=%b expected pc=80 epc=100 valid=0 mis=0",
                               pc_out, epc_out, pc_valid, misaligned); end
        // A redirect during the trap bubble must be ignored.
        redirect_valid = 1'b1; redirect_target = 32'h300;
        step();
        redirect_valid = 1'b0;
        checks++; if (pc_out !== 32'h80 || pc_valid !== 1'b1) begin
            errors++; $display("FAIL trap_exit: got pc=%h valid=%b expected pc=80 valid=1", pc_out, pc_valid); end
        step();
        checks++; if (pc_out !== 32'h84) begin errors++; $display("FAIL after_trap: got %h expected 84", pc_out); end
        $display("test_redirect done");
    endtask

    task automatic test_call_return();
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'h54; exp_ret[1] = 32'h44; exp_ret[2] = 32'h34; exp_ret[3] = 32'h24;
        for (int i = 0; i < 5; i++) begin
            go_to(32'(16 * (i + 1)));
            redirect_valid = 1'b1; redirect_target = 32'h1000; redirect_call = 1'b1;
            step();
            redirect_valid = 1'b0; redirect_call = 1'b0;
            stall = 1'b1;
            if (i == 2) begin
                checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL ras_full_early: got %b expected 0", ras_full); end
            end
            if (i >= 3) begin
                checks++; if (ras_full !== 1'b1 || ras_empty !== 1'b0) begin
                    errors++; $display("FAIL ras_full_call%0d: got full=%b empty=%b expected full=1 empty=0", i + 1, ras_full, ras_empty); end
            end
            stall = 1'b0;
        end
        // Return without adv is held off.
        stall = 1'b1; ret_valid = 1'b1;
        step();
        checks++; if (pc_out !== 32'h1000 || ras_full !== 1'b1) begin
            errors++; $display("FAIL ret_held: got pc=%h full=%b expected pc=1000 full=1", pc_out, ras_full); end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (pc_out !== exp_ret[i]) begin errors++; $display("FAIL ret%0d: got %h expected %h", i + 1, pc_out, exp_ret[i]); end
        end
        checks++; if (ras_empty !== 1'b1 || ret_miss !== 1'b0) begin
            errors++; $display("FAIL ras_drained: got empty=%b miss=%b expected empty=1 miss=0", ras_empty, ret_miss); end
        step();
        ret_valid = 1'b0;
        checks++; if (pc_out !== 32'h28 || ret_miss !== 1'b1 || ras_empty !== 1'b1) begin
            errors++; $display("FAIL ret_miss: got pc=%h miss=%b empty=%b expected pc=28 miss=1 empty=1", pc_out, ret_miss, ras_empty); end
        step();
        checks++; if (pc_out !== 32'h2C || ret_miss !== 1'b0) begin
            errors++; $display("FAIL ret_miss_pulse: got pc=%h miss=%b expected pc=2c miss=0", pc_out, ret_miss); end
        $display("test_call_return done");
    endtask

    task automatic test_wrap();
        go_to(32'hFFFF_FFFC);
        checks++; if (pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %h expected fffffffc", pc_out); end
        step();
        checks++; if (pc_out !== 32'h0 || misaligned !== 1'b0 || ret_miss !== 1'b0 || pc_valid !== 1'b1) begin
            errors++; $display("FAIL wrap: got pc=%h mis=%b miss=%b valid=%b expected pc=0 mis=0 miss=0 valid=1",
                               pc_out, misaligned, ret_miss, pc_valid); end
        $display("test_wrap done");
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_call_return();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
